// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with wrap-bit pointers, registered read data and async active-low reset
//   clk      sole clock, rising edge
//   rst      asynchronous active-low reset (0 = in reset)
//   wr_en    push request, accepted when !full
//   wr_data  word pushed on an accepted push
//   full     no free entries
//   rd_en    pop request, accepted when !empty
//   rd_data  registered word from the last accepted pop
//   empty    no stored entries
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_SIZE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
);
  localparam int DEPTH = 1 << PTR_SIZE;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_SIZE:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  do_push, do_pop;
  // The extra MSB distinguishes full from empty when the address bits match.
  always_comb begin
    empty     = wr_ptr_q == rd_ptr_q;
    full      = (wr_ptr_q[PTR_SIZE-1:0] == rd_ptr_q[PTR_SIZE-1:0]) && (wr_ptr_q[PTR_SIZE] != rd_ptr_q[PTR_SIZE]);
    do_push   = wr_en && !full;
    do_pop    = rd_en && !empty;
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data_d = do_pop ? mem_q[rd_ptr_q[PTR_SIZE-1:0]] : rd_data_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end
  // Storage is deliberately not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_SIZE-1:0]] <= wr_data;
  end
  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: randomized and directed checks of async_fifo against a queue-based model
module tb_async_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  int         passed = 0;
  int         total = 0;
  logic [7:0] m_q [$];
  logic [7:0] m_rd = '0;
  logic [7:0] saved [10];
  logic [7:0] last;
  bit         chk_on = 1'b0;
  async_fifo #(.DATA_WIDTH(8), .PTR_SIZE(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // Model: flags and read data follow from queue occupancy sampled before the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    bit p, o;
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    p = w && m_q.size() < 16;
    o = r && m_q.size() > 0;
    if (o) m_rd = m_q.pop_front();
    if (p) m_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("full", 32'(full), 32'(m_q.size() == 16));
      check("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end
  initial begin
    #12 rst = 1'b1;
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    chk_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      saved[i] = 8'($urandom);
      cyc(1'b1, saved[i], 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check("order", 32'(rd_data), 32'(saved[i]));
    end
    check("order_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    cyc(1'b1, 8'hAA, 1'b0);
    check("drop_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check("fill_pop", 32'(rd_data), 32'(i));
    end
    check("fill_empty", 32'(empty), 32'd1);
    last = rd_data;
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    check("underflow_empty", 32'(empty), 32'd1);
    check("underflow_hold", 32'(rd_data), 32'h0F);
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("after_underflow", 32'(rd_data), 32'h3C);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'($urandom), 1'b1);
      check("simul_count", 32'(m_q.size()), 32'd5);
    end
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'($urandom), 1'b0);
    check("simul_full", 32'(full), 32'd1);
    cyc(1'b1, 8'h77, 1'b1);
    check("full_both_full", 32'(full), 32'd0);
    check("full_both_count", 32'(m_q.size()), 32'd15);
    for (int i = 0; i < 300; i++) cyc(1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'($urandom), 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midreset_empty", 32'(empty), 32'd1);
    check("midreset_full", 32'(full), 32'd0);
    check("midreset_rd_data", 32'(rd_data), 32'd0);
    m_q.delete();
    m_rd = '0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 8'h5C, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("midreset_5c", 32'(rd_data), 32'h5C);
    check("midreset_end_empty", 32'(empty), 32'd1);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
